// File: rtl/mips_regfile_pkg.sv
// Shared constants and the write-queue entry type for the MIPS register file.
// Macro REGFILE_WRITE_BYPASS_EN (used in regfile_write_port) enables the
// read-side overlay of queued writes.
package mips_regfile_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_GP   = 5'd28;
  localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;

  // One queued write-back request
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/regfile_write_decoder.sv
// 5-to-32 one-hot decoder with enable; bit 0 is always masked because
// register $zero is never written.
// Ports:
//   i_en        decode enable
//   i_addr      register number
//   o_onehot_c  combinational one-hot strobe (0 when disabled or addr 0)
module regfile_write_decoder
  import mips_regfile_pkg::*;
(
  input  logic                i_en,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [NUM_REGS-1:0] o_onehot_c
);

  always_comb begin
    o_onehot_c = '0;
    if (i_en && (i_addr != REG_ZERO)) o_onehot_c[i_addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_port.sv
// Write side of the 32-entry MIPS register file. Write-back requests are
// accepted over valid/ready into a small in-order queue and committed at most
// one per cycle into register storage; all registers are presented flattened
// on Reg_Data for the read multiplexers.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN -- when defined, Reg_Data is
// overlaid with the queued (uncommitted) writes, newest winning per address.
// Ports:
//   clk, reset     clock (rising edge), asynchronous active-low reset
//   Wr_Valid/Ready request handshake (Ready is combinational)
//   Wr_Addr/Data   destination register and write-back data
//   Commit_Stall   hold the queue head this cycle
//   Flush          drop all queued writes (highest priority)
//   Wr_Strobe      registered one-hot of the register committed at last edge
//   Pending_Count  queued entries
//   Reg_Data       register r at bits [r*N +: N]
module regfile_write_port
  import mips_regfile_pkg::*;
#(
  parameter int unsigned N        = 32,
  parameter int unsigned DEPTH    = 2,
  parameter logic [N-1:0] SP_RESET = 32'h7FFF_EFFC,
  parameter logic [N-1:0] GP_RESET = 32'h1000_8000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Wr_Valid,
  output logic                  Wr_Ready,
  input  logic [ADDR_W-1:0]     Wr_Addr,
  input  logic [N-1:0]          Wr_Data,
  input  logic                  Commit_Stall,
  input  logic                  Flush,
  output logic [NUM_REGS-1:0]   Wr_Strobe,
  output logic [1:0]            Pending_Count,
  output logic [NUM_REGS*N-1:0] Reg_Data
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_entry_t             r_q [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [1:0]            r_count;
  logic [NUM_REGS-1:0]   r_strobe;
  logic [N-1:0]          r_regs [1:NUM_REGS-1];

  logic                  w_ready;
  logic                  w_accept;
  logic                  w_commit;
  wr_entry_t             w_head;
  logic [NUM_REGS-1:0]   w_strobe;
  logic [NUM_REGS*N-1:0] w_flat;

  // Pointer advance, wrapping modulo DEPTH
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign w_ready  = (r_count < 2'(DEPTH)) && !Flush;
  assign w_accept = Wr_Valid && w_ready;
  assign w_commit = (r_count != 2'd0) && !Commit_Stall && !Flush;
  assign w_head   = r_q[r_rd_ptr];

  regfile_write_decoder u_dec (
    .i_en       (w_commit),
    .i_addr     (w_head.addr),
    .o_onehot_c (w_strobe)
  );

  // Write queue: tail push on accept, head pop on commit, flush empties it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 2'd0;
      for (int unsigned i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (Flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 2'd0;
    end else begin
      if (w_accept) begin
        r_q[r_wr_ptr] <= '{addr: Wr_Addr, data: DATA_W'(Wr_Data)};
        r_wr_ptr      <= ptr_next(r_wr_ptr);
      end
      if (w_commit) r_rd_ptr <= ptr_next(r_rd_ptr);
      case ({w_accept, w_commit})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Register storage; $zero has no storage at all
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (ADDR_W'(r) == REG_GP)      r_regs[r] <= GP_RESET;
        else if (ADDR_W'(r) == REG_SP) r_regs[r] <= SP_RESET;
        else                           r_regs[r] <= '0;
      end
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (w_strobe[r]) r_regs[r] <= N'(w_head.data);
      end
    end
  end

  // Strobe is the decoded commit, so it is already 0 on stall/flush/empty
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_strobe <= '0;
    else        r_strobe <= w_strobe;
  end

  // Flattened read view, optionally overlaid with queued writes oldest-first
  always_comb begin
    w_flat = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) w_flat[r*N +: N] = r_regs[r];
`ifdef REGFILE_WRITE_BYPASS_EN
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((32'(r_rd_ptr) + i) % DEPTH);
      if ((i < 32'(r_count)) && (r_q[idx].addr != REG_ZERO))
        w_flat[32'(r_q[idx].addr)*N +: N] = N'(r_q[idx].data);
    end
`endif
  end

  assign Wr_Ready      = w_ready;
  assign Wr_Strobe     = r_strobe;
  assign Pending_Count = r_count;
  assign Reg_Data      = w_flat;

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: stimulus drives at the falling edge and pushes
// the expected post-edge response of a queue/array reference model into a
// scoreboard; a monitor pops and compares after each rising edge.
module tb_regfile_write_port;

  localparam int unsigned N     = 32;
  localparam int unsigned NR    = 32;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] SP_RST = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_RST = 32'h1000_8000;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            Wr_Valid = 1'b0;
  logic            Wr_Ready;
  logic [4:0]      Wr_Addr = '0;
  logic [N-1:0]    Wr_Data = '0;
  logic            Commit_Stall = 1'b0;
  logic            Flush = 1'b0;
  logic [NR-1:0]   Wr_Strobe;
  logic [1:0]      Pending_Count;
  logic [NR*N-1:0] Reg_Data;

  regfile_write_port dut (
    .clk           (clk),
    .reset         (reset),
    .Wr_Valid      (Wr_Valid),
    .Wr_Ready      (Wr_Ready),
    .Wr_Addr       (Wr_Addr),
    .Wr_Data       (Wr_Data),
    .Commit_Stall  (Commit_Stall),
    .Flush         (Flush),
    .Wr_Strobe     (Wr_Strobe),
    .Pending_Count (Pending_Count),
    .Reg_Data      (Reg_Data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic [31:0]      strobe;
    logic [1:0]       cnt;
    logic             ready;
    logic [NR*N-1:0]  regs;
  } exp_t;

  ent_t        mq[$];
  logic [31:0] mregs [NR];
  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) mregs[i] = '0;
    mregs[28] = GP_RST;
    mregs[29] = SP_RST;
    mq.delete();
  endfunction

  function automatic logic [NR*N-1:0] model_view();
    logic [NR*N-1:0] v;
    v = '0;
    for (int r = 1; r < NR; r++) v[r*N +: N] = mregs[r];
`ifdef REGFILE_WRITE_BYPASS_EN
    foreach (mq[k]) if (mq[k].a != 5'd0) v[int'(mq[k].a)*N +: N] = mq[k].d;
`endif
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_regs(input string name, input logic [NR*N-1:0] act, input logic [NR*N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      for (int r = 0; r < NR; r++) begin
        if (act[r*N +: N] !== exp[r*N +: N]) begin
          $display("FAIL %s: reg %0d got %h expected %h (t=%0t)", name, r,
                   act[r*N +: N], exp[r*N +: N], $time);
          break;
        end
      end
    end
  endtask

  // Immediate full-state check against the model (used around reset)
  task automatic check_now(input string name);
    chk({name, "_strobe"}, Wr_Strobe, 32'd0);
    chk({name, "_count"}, 32'(Pending_Count), 32'(mq.size()));
    chk({name, "_ready"}, 32'(Wr_Ready), 32'(!Flush));
    chk_regs({name, "_regs"}, Reg_Data, model_view());
  endtask

  // Drive one cycle of stimulus and record the expected post-edge response
  task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                       input logic st, input logic fl);
    exp_t e;
    ent_t h;
    ent_t t;
    bit   acc;
    @(negedge clk);
    Wr_Valid = v; Wr_Addr = a; Wr_Data = d; Commit_Stall = st; Flush = fl;
    #1;
    chk("wr_ready_pre", 32'(Wr_Ready), 32'((mq.size() < DEPTH) && !fl));
    acc = v && (mq.size() < DEPTH) && !fl;
    e.strobe = '0;
    if (fl) begin
      mq.delete();
    end else begin
      if ((mq.size() > 0) && !st) begin
        h = mq.pop_front();
        if (h.a != 5'd0) begin
          mregs[h.a] = h.d;
          e.strobe = 32'd1 << h.a;
        end
      end
      if (acc) begin
        t.a = a; t.d = d;
        mq.push_back(t);
      end
    end
    e.cnt   = 2'(mq.size());
    e.ready = (mq.size() < DEPTH) && !fl;
    e.regs  = model_view();
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // Position just after the next rising edge for a directed spot check
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare after every rising edge for which an expectation exists
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("strobe", Wr_Strobe, e.strobe);
        chk("pending_count", 32'(Pending_Count), 32'(e.cnt));
        chk("wr_ready", 32'(Wr_Ready), 32'(e.ready));
        chk_regs("reg_data", Reg_Data, e.regs);
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_now("in_reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_now("reset_release");
    chk("sp_reset", Reg_Data[29*N +: N], 32'h7FFF_EFFC);
    chk("gp_reset", Reg_Data[28*N +: N], 32'h1000_8000);
    chk("zero_reset", Reg_Data[0 +: N], 32'd0);

    // Single write to r8
    cycle(1'b1, 5'd8, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("r8_strobe", Wr_Strobe, 32'h0000_0100);
    chk("r8_data", Reg_Data[8*N +: N], 32'hDEAD_BEEF);

    // Stalled queue fills; third request waits, then in-order drain
    cycle(1'b1, 5'd1, 32'h0000_0011, 1'b1, 1'b0);
    cycle(1'b1, 5'd2, 32'h0000_0022, 1'b1, 1'b0);
    cycle(1'b1, 5'd3, 32'h0000_0033, 1'b1, 1'b0);
    cycle(1'b1, 5'd3, 32'h0000_0033, 1'b1, 1'b0);
    cycle(1'b1, 5'd3, 32'h0000_0033, 1'b0, 1'b0);
    cycle(1'b1, 5'd3, 32'h0000_0033, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    idle(1);

    // Write to $zero consumes a slot but never strobes
    cycle(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    settle();
    chk("zero_strobe", Wr_Strobe, 32'd0);
    chk("zero_data", Reg_Data[0 +: N], 32'd0);

    // Same-register back-to-back: later data survives
    cycle(1'b1, 5'd7, 32'h0000_0001, 1'b0, 1'b0);
    cycle(1'b1, 5'd7, 32'h0000_0002, 1'b0, 1'b0);
    idle(2);

    // Flush with a same-cycle request
    cycle(1'b1, 5'd10, 32'hAAAA_0001, 1'b1, 1'b0);
    cycle(1'b1, 5'd11, 32'hAAAA_0002, 1'b1, 1'b0);
    cycle(1'b1, 5'd12, 32'hAAAA_0003, 1'b0, 1'b1);
    idle(2);

    // Stalled write to r5: visible early only with the bypass overlay
    cycle(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    settle();
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("r5_stalled", Reg_Data[5*N +: N], 32'h0000_1234);
`else
    chk("r5_stalled", Reg_Data[5*N +: N], 32'h0000_0000);
`endif
    idle(2);

    // Reset asserted with writes queued
    cycle(1'b1, 5'd20, 32'h5555_0001, 1'b1, 1'b0);
    cycle(1'b1, 5'd21, 32'h5555_0002, 1'b1, 1'b0);
    @(negedge clk);
    Wr_Valid = 1'b0; Flush = 1'b0; Commit_Stall = 1'b0;
    reset = 1'b0;
    #1;
    model_reset();
    check_now("mid_reset");
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(99) < 65, 5'($urandom_range(31)), $urandom(),
            $urandom_range(99) < 30, $urandom_range(99) < 4);
    end
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
